pwm_decoder: RTL

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sync_edge.sv | 30 +++
 rtl/pwm_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: PWM framing constants, counter widths and
// the decoder state encoding.
package audio_pkg;

  localparam int unsigned PWM_PERIOD   = 4095;
  localparam int unsigned CNT_W        = 13;
  localparam int unsigned SAMPLE_W     = 12;

  localparam int unsigned DEC_PERIOD   = PWM_PERIOD;
  localparam int unsigned DEC_TOL      = 4;
  localparam int unsigned DEC_LOCK_CNT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } dec_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus a third flop that
// turns the synchronised level into a single-cycle rising-edge strobe.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers duty-cycle samples from a PWM audio stream, measures its period,
// flags out-of-tolerance periods and a stuck input, and reports lock.
module pwm_decoder
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD   = DEC_PERIOD,
  parameter int unsigned TOL      = DEC_TOL,
  parameter int unsigned LOCK_CNT = DEC_LOCK_CNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic [CNT_W-1:0]    period,
  output logic                period_err,
  output logic                stuck,
  output logic                locked
);

  localparam int unsigned       LOCK_W     = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  PER_C      = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0]  TOL_C      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_C     = LOCK_W'(LOCK_CNT);
  localparam logic [SAMPLE_W-1:0] SMP_MAX  = '1;

  logic w_level;
  logic w_rise;

  dec_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_per_cnt, w_per_nxt;
  logic [CNT_W-1:0]    r_hi_cnt, w_hi_nxt;
  logic [SAMPLE_W-1:0] r_sample, w_sample_nxt;
  logic                r_valid, w_valid_nxt;
  logic [CNT_W-1:0]    r_period, w_period_nxt;
  logic                r_err, w_err_nxt;
  logic                r_stuck, w_stuck_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt, w_lock_nxt;

  logic [CNT_W-1:0]    w_per_dev;
  logic                w_per_bad;
  logic [SAMPLE_W-1:0] w_hi_clip;
  logic [SAMPLE_W-1:0] w_level_smp;
  logic [LOCK_W-1:0]   w_lock_inc;

  sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_per_dev   = (r_per_cnt >= PER_C) ? (r_per_cnt - PER_C) : (PER_C - r_per_cnt);
  assign w_per_bad   = (w_per_dev > TOL_C);
  assign w_hi_clip   = (r_hi_cnt > CNT_W'(SMP_MAX)) ? SMP_MAX : r_hi_cnt[SAMPLE_W-1:0];
  assign w_level_smp = w_level ? SMP_MAX : '0;
  assign w_lock_inc  = (r_lock_cnt >= LOCK_C) ? r_lock_cnt : r_lock_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A rise restarts both counters at 1: the edge cycle is the first cycle of
  // the new period and is already high.
  always_comb begin
    w_state_nxt  = r_state;
    w_per_nxt    = r_per_cnt;
    w_hi_nxt     = r_hi_cnt;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_period_nxt = r_period;
    w_err_nxt    = r_err;
    w_stuck_nxt  = r_stuck;
    w_lock_nxt   = r_lock_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_per_nxt   = ONE_C;
          w_hi_nxt    = ONE_C;
        end
      end

      ST_MEASURE: begin
        if (w_rise) begin
          w_per_nxt    = ONE_C;
          w_hi_nxt     = ONE_C;
          w_period_nxt = r_per_cnt;
          w_sample_nxt = w_hi_clip;
          w_valid_nxt  = 1'b1;
          w_err_nxt    = w_per_bad;
          w_lock_nxt   = w_per_bad ? '0 : w_lock_inc;
        end else if (r_per_cnt >= TIMEOUT_C) begin
          w_state_nxt  = ST_STUCK;
          w_stuck_nxt  = 1'b1;
          w_sample_nxt = w_level_smp;
          w_valid_nxt  = 1'b1;
          w_period_nxt = PER_C;
          w_err_nxt    = 1'b0;
          w_lock_nxt   = '0;
          w_per_nxt    = ONE_C;
          w_hi_nxt     = '0;
        end else begin
          w_per_nxt = sat_inc(r_per_cnt);
          w_hi_nxt  = w_level ? sat_inc(r_hi_cnt) : r_hi_cnt;
        end
      end

      ST_STUCK: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_stuck_nxt = 1'b0;
          w_per_nxt   = ONE_C;
          w_hi_nxt    = ONE_C;
        end else if (r_per_cnt >= PER_C) begin
          w_per_nxt    = ONE_C;
          w_sample_nxt = w_level_smp;
          w_valid_nxt  = 1'b1;
        end else begin
          w_per_nxt = sat_inc(r_per_cnt);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_per_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_period   <= '0;
      r_err      <= 1'b0;
      r_stuck    <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_per_cnt  <= w_per_nxt;
      r_hi_cnt   <= w_hi_nxt;
      r_sample   <= w_sample_nxt;
      r_valid    <= w_valid_nxt;
      r_period   <= w_period_nxt;
      r_err      <= w_err_nxt;
      r_stuck    <= w_stuck_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign period       = r_period;
  assign period_err   = r_err;
  assign stuck        = r_stuck;
  assign locked       = (r_lock_cnt >= LOCK_C);

endmodule
